// File: rtl/control_seq_pkg.sv
// Shared types for the VeriRISC sequence controller: opcodes, phase encoding and
// the ALU-opcode classification helper.
package control_seq_pkg;

  typedef enum logic [2:0] {
    OpHlt = 3'd0,
    OpSkz = 3'd1,
    OpAdd = 3'd2,
    OpAnd = 3'd3,
    OpXor = 3'd4,
    OpLda = 3'd5,
    OpSto = 3'd6,
    OpJmp = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    StInstAddr  = 4'd0,
    StInstFetch = 4'd1,
    StInstLoad  = 4'd2,
    StIdle      = 4'd3,
    StOpAddr    = 4'd4,
    StOpFetch   = 4'd5,
    StAluOp     = 4'd6,
    StStore     = 4'd7,
    StHalted    = 4'd8,
    StPause     = 4'd9
  } seq_state_t;

  // One bit per opcode value: ADD, AND, XOR, LDA read memory into the accumulator.
  localparam logic [7:0] AluOpSet = 8'b0011_1100;

  function automatic logic is_aluop(input opcode_t op);
    return AluOpSet[op];
  endfunction

endpackage

// File: rtl/control_wait_timer.sv
// Memory wait-state tracker: decides whether the current phase may advance and
// flags a timeout when an access is held for WAIT_MAX cycles.
module control_wait_timer #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned WAIT_MAX    = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_phase_i,
  input  logic mem_ready_i,
  output logic advance_o,
  output logic timeout_o
);

  localparam int unsigned CntW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CntW-1:0] CntLast = (WAIT_MAX == 0) ? '0 : CntW'(WAIT_MAX - 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            stall;

  assign stall = MEM_WAIT_EN && wait_phase_i && !mem_ready_i;

  always_comb begin
    wait_cnt_d = '0;
    timeout_o  = 1'b0;
    advance_o  = !stall;
    if (stall) begin
      // Ready on the last allowed cycle still completes; only a held cycle times out.
      if ((WAIT_MAX != 0) && (wait_cnt_q == CntLast)) begin
        timeout_o = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/control_seq.sv
// VeriRISC sequence controller: walks the 8-phase fetch/execute cycle, decodes
// control strobes, and handles halt, single-step pause and memory wait states.
module control_seq
  import control_seq_pkg::*;
#(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned WAIT_MAX    = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       opcode_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  input  logic             resume_i,
  input  logic             step_en_i,
  output logic             mem_rd_o,
  output logic             load_ir_o,
  output logic             halt_o,
  output logic             inc_pc_o,
  output logic             load_ac_o,
  output logic             load_pc_o,
  output logic             mem_wr_o,
  output logic             paused_o,
  output logic             bus_err_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  opcode_t          op;
  seq_state_t       state_q;
  logic [CNT_W-1:0] instr_cnt_q;
  logic             bus_err_q;
  logic             alu, wait_phase, advance, timeout;

  assign op  = opcode_t'(opcode_i);
  assign alu = is_aluop(op);

  assign wait_phase = (state_q == StInstFetch) ||
                      ((state_q == StOpFetch) && alu) ||
                      ((state_q == StStore) && (op == OpSto));

  control_wait_timer #(
    .MEM_WAIT_EN(MEM_WAIT_EN),
    .WAIT_MAX   (WAIT_MAX)
  ) u_wait_timer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wait_phase_i(wait_phase),
    .mem_ready_i (mem_ready_i),
    .advance_o   (advance),
    .timeout_o   (timeout)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StInstAddr;
      instr_cnt_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      case (state_q)
        StInstAddr: state_q <= StInstFetch;
        StInstFetch: begin
          if (timeout) begin
            bus_err_q <= 1'b1;
            state_q   <= StHalted;
          end else if (advance) begin
            state_q <= StInstLoad;
          end
        end
        StInstLoad: state_q <= StIdle;
        StIdle:     state_q <= StOpAddr;
        StOpAddr:   state_q <= (op == OpHlt) ? StHalted : StOpFetch;
        StOpFetch: begin
          if (timeout) begin
            bus_err_q <= 1'b1;
            state_q   <= StHalted;
          end else if (advance) begin
            state_q <= StAluOp;
          end
        end
        StAluOp: state_q <= StStore;
        StStore: begin
          if (timeout) begin
            bus_err_q <= 1'b1;
            state_q   <= StHalted;
          end else if (advance) begin
            instr_cnt_q <= instr_cnt_q + 1'b1;
            state_q     <= step_en_i ? StPause : StInstAddr;
          end
        end
        StHalted: begin
          if (resume_i) begin
            bus_err_q <= 1'b0;
            state_q   <= StInstAddr;
          end
        end
        StPause: if (resume_i) state_q <= StInstAddr;
        default: state_q <= StInstAddr;
      endcase
    end
  end

  always_comb begin
    mem_rd_o  = 1'b0;
    load_ir_o = 1'b0;
    halt_o    = 1'b0;
    inc_pc_o  = 1'b0;
    load_ac_o = 1'b0;
    load_pc_o = 1'b0;
    mem_wr_o  = 1'b0;
    paused_o  = 1'b0;
    case (state_q)
      StInstFetch: mem_rd_o = 1'b1;
      StInstLoad, StIdle: begin
        mem_rd_o  = 1'b1;
        load_ir_o = 1'b1;
      end
      StOpAddr: begin
        inc_pc_o = 1'b1;
        halt_o   = (op == OpHlt);
      end
      StOpFetch: mem_rd_o = alu;
      StAluOp: begin
        mem_rd_o  = alu;
        load_ac_o = alu;
        inc_pc_o  = (op == OpSkz) && zero_i;
        load_pc_o = (op == OpJmp);
      end
      StStore: begin
        mem_rd_o  = alu;
        load_ac_o = alu;
        inc_pc_o  = (op == OpJmp);
        load_pc_o = (op == OpJmp);
        mem_wr_o  = (op == OpSto);
      end
      StHalted: halt_o   = 1'b1;
      StPause:  paused_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o     = state_q;
  assign instr_cnt_o = instr_cnt_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_control_seq.sv
// Scoreboard bench for control_seq: stimulus queues per-cycle expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_control_seq;
  import control_seq_pkg::*;

  localparam logic [8:0] S_RD   = 9'h100;
  localparam logic [8:0] S_IR   = 9'h080;
  localparam logic [8:0] S_HALT = 9'h040;
  localparam logic [8:0] S_INC  = 9'h020;
  localparam logic [8:0] S_AC   = 9'h010;
  localparam logic [8:0] S_PC   = 9'h008;
  localparam logic [8:0] S_WR   = 9'h004;
  localparam logic [8:0] S_PAU  = 9'h002;
  localparam logic [8:0] S_ERR  = 9'h001;
  localparam logic [8:0] S_NONE = 9'h000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       resume = 1'b0;
  logic       step_en = 1'b0;
  logic       mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, paused, bus_err;
  logic [3:0] state;
  logic [3:0] instr_cnt;
  logic [8:0] act;

  control_seq #(
    .MEM_WAIT_EN(1'b1),
    .WAIT_MAX   (4),
    .CNT_W      (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .opcode_i   (opcode),
    .zero_i     (zero),
    .mem_ready_i(mem_ready),
    .resume_i   (resume),
    .step_en_i  (step_en),
    .mem_rd_o   (mem_rd),
    .load_ir_o  (load_ir),
    .halt_o     (halt),
    .inc_pc_o   (inc_pc),
    .load_ac_o  (load_ac),
    .load_pc_o  (load_pc),
    .mem_wr_o   (mem_wr),
    .paused_o   (paused),
    .bus_err_o  (bus_err),
    .state_o    (state),
    .instr_cnt_o(instr_cnt)
  );

  always #5 clk = ~clk;

  assign act = {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr, paused, bus_err};

  typedef struct {
    string      nm;
    logic [3:0] st;
    logic [8:0] strb;
    logic [3:0] cnt;
  } exp_t;

  exp_t  sbq[$];
  exp_t  mon_e;
  string tname = "reset";
  int    n_checks = 0;
  int    n_fails = 0;
  logic [3:0] n = 4'd0;

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      n_checks++;
      if (state !== mon_e.st || act !== mon_e.strb || instr_cnt !== mon_e.cnt) begin
        n_fails++;
        $display("FAIL %s/%s: got state=%0d strobes=%b cnt=%0d, required state=%0d strobes=%b cnt=%0d",
                 tname, mon_e.nm, state, act, instr_cnt, mon_e.st, mon_e.strb, mon_e.cnt);
      end
    end
  end

  task automatic cyc(input string nm, input logic [3:0] st, input logic [8:0] strb,
                     input logic [3:0] cnt);
    exp_t e;
    e.nm   = nm;
    e.st   = st;
    e.strb = strb;
    e.cnt  = cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [3:0] c);
    cyc("inst_addr", StInstAddr, S_NONE, c);
    cyc("inst_fetch", StInstFetch, S_RD, c);
    cyc("inst_load", StInstLoad, S_RD | S_IR, c);
    cyc("idle", StIdle, S_RD | S_IR, c);
  endtask

  task automatic body(input logic [3:0] c, input logic [8:0] e_oa, input logic [8:0] e_of,
                      input logic [8:0] e_alu, input logic [8:0] e_st);
    cyc("op_addr", StOpAddr, e_oa, c);
    cyc("op_fetch", StOpFetch, e_of, c);
    cyc("alu_op", StAluOp, e_alu, c);
    cyc("store", StStore, e_st, c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", StInstAddr, S_NONE, 4'd0);
    rst = 1'b0;

    tname = "add";
    opcode = OpAdd;
    fetch(n);
    body(n, S_INC, S_RD, S_RD | S_AC, S_RD | S_AC);
    n = 4'd1;

    // resume held high throughout must be ignored outside HALTED/PAUSE
    tname = "skz_zero1";
    opcode = OpSkz; zero = 1'b1; resume = 1'b1;
    fetch(n);
    body(n, S_INC, S_NONE, S_INC, S_NONE);
    resume = 1'b0;
    n = 4'd2;

    tname = "skz_zero0";
    zero = 1'b0;
    fetch(n);
    body(n, S_INC, S_NONE, S_NONE, S_NONE);
    n = 4'd3;

    tname = "jmp";
    opcode = OpJmp;
    fetch(n);
    body(n, S_INC, S_NONE, S_PC, S_INC | S_PC);
    n = 4'd4;

    tname = "hlt";
    opcode = OpHlt;
    fetch(n);
    cyc("op_addr", StOpAddr, S_INC | S_HALT, n);
    for (int i = 0; i < 20; i++) cyc("halted_hold", StHalted, S_HALT, n);
    resume = 1'b1;
    cyc("halted_resume", StHalted, S_HALT, n);
    resume = 1'b0;

    tname = "sto_wait";
    opcode = OpSto;
    fetch(n);
    cyc("op_addr", StOpAddr, S_INC, n);
    cyc("op_fetch", StOpFetch, S_NONE, n);
    cyc("alu_op", StAluOp, S_NONE, n);
    mem_ready = 1'b0;
    cyc("store_w0", StStore, S_WR, n);
    cyc("store_w1", StStore, S_WR, n);
    mem_ready = 1'b1;
    cyc("store_go", StStore, S_WR, n);
    n = 4'd5;

    // ready arriving on the would-be timeout cycle completes the access
    tname = "lda_ready_at_limit";
    opcode = OpLda;
    fetch(n);
    cyc("op_addr", StOpAddr, S_INC, n);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("op_fetch_wait", StOpFetch, S_RD, n);
    mem_ready = 1'b1;
    cyc("op_fetch_go", StOpFetch, S_RD, n);
    cyc("alu_op", StAluOp, S_RD | S_AC, n);
    cyc("store", StStore, S_RD | S_AC, n);
    n = 4'd6;

    tname = "fetch_timeout";
    opcode = OpAdd;
    cyc("inst_addr", StInstAddr, S_NONE, n);
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("inst_fetch_wait", StInstFetch, S_RD, n);
    cyc("halted_err0", StHalted, S_HALT | S_ERR, n);
    cyc("halted_err1", StHalted, S_HALT | S_ERR, n);
    mem_ready = 1'b1;
    resume = 1'b1;
    cyc("halted_resume", StHalted, S_HALT | S_ERR, n);
    resume = 1'b0;
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_fails++;
      $display("FAIL %s/bus_err_clear: got bus_err=%b, required 0", tname, bus_err);
    end
    cyc("err_cleared", StInstAddr, S_NONE, n);
    cyc("inst_fetch", StInstFetch, S_RD, n);
    cyc("inst_load", StInstLoad, S_RD | S_IR, n);
    cyc("idle", StIdle, S_RD | S_IR, n);
    body(n, S_INC, S_RD, S_RD | S_AC, S_RD | S_AC);
    n = 4'd7;

    tname = "step_lda";
    opcode = OpLda; step_en = 1'b1;
    fetch(n);
    body(n, S_INC, S_RD, S_RD | S_AC, S_RD | S_AC);
    n = 4'd8;
    cyc("pause0", StPause, S_PAU, n);
    cyc("pause1", StPause, S_PAU, n);
    resume = 1'b1;
    cyc("pause_resume", StPause, S_PAU, n);
    resume = 1'b0;
    fetch(n);
    body(n, S_INC, S_RD, S_RD | S_AC, S_RD | S_AC);
    n = 4'd9;
    cyc("pause_again", StPause, S_PAU, n);
    step_en = 1'b0;
    resume = 1'b1;
    cyc("pause_resume2", StPause, S_PAU, n);
    resume = 1'b0;

    tname = "rst_mid_wait";
    opcode = OpAdd;
    cyc("inst_addr", StInstAddr, S_NONE, n);
    mem_ready = 1'b0;
    cyc("inst_fetch_w0", StInstFetch, S_RD, n);
    cyc("inst_fetch_w1", StInstFetch, S_RD, n);
    rst = 1'b1;
    #1;
    n_checks++;
    if (act !== S_NONE || state !== StInstAddr || instr_cnt !== 4'd0) begin
      n_fails++;
      $display("FAIL %s/async_now: got state=%0d strobes=%b cnt=%0d, required state=%0d strobes=%b cnt=0",
               tname, state, act, instr_cnt, StInstAddr, S_NONE);
    end
    cyc("async_reset", StInstAddr, S_NONE, 4'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    n = 4'd0;

    tname = "cnt_wrap";
    for (int i = 0; i < 16; i++) begin
      fetch(n);
      body(n, S_INC, S_RD, S_RD | S_AC, S_RD | S_AC);
      n = n + 4'd1;
    end
    cyc("wrapped", StInstAddr, S_NONE, 4'd0);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_fails++;
      $display("FAIL end: got %0d unchecked expectations, required 0", sbq.size());
    end
    if (n_checks < 12) begin
      n_fails++;
      $display("FAIL end: got %0d checks, required at least 12", n_checks);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
